// File: rtl/osg_frame_loader_if.sv
// Rx byte stream in, channel register-file write port and control strobes out.
interface osg_frame_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        run_active;
  logic        cfg_we;
  logic [7:0]  cfg_ch;
  logic [16:0] cfg_drt;
  logic [16:0] cfg_del;
  logic [4:0]  cfg_mpl;
  logic [4:0]  cfg_mdl;
  logic [3:0]  cfg_ts;
  logic        pc_start;
  logic        frame_err;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, run_active,
    output cfg_we, cfg_ch, cfg_drt, cfg_del, cfg_mpl, cfg_mdl, cfg_ts,
           pc_start, frame_err, busy
  );

  modport slave (
    output rx_data, rx_valid, run_active,
    input  cfg_we, cfg_ch, cfg_drt, cfg_del, cfg_mpl, cfg_mdl, cfg_ts,
           pc_start, frame_err, busy
  );
endinterface

// File: rtl/osg_frame_loader.sv
// Frame parser: UART Rx bytes -> validated per-channel timing records and the PC start strobe.
// A commit leaves COMMIT straight to IDLE on the same edge that raises cfg_we/pc_start.
module osg_frame_loader #(
  parameter int         NCH         = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] SYNC        = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  osg_frame_loader_if.master  bus
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    NCH_B    = 8'(NCH);
  localparam logic [7:0]    START_CH = 8'hFF;

  typedef enum logic [2:0] {IDLE, HDR, BODY, CHK, START_CHK, COMMIT} st_t;

  typedef struct packed {
    logic [7:0]  ch;
    logic [16:0] drt;
    logic [16:0] del;
    logic [4:0]  mpl;
    logic [4:0]  mdl;
    logic [3:0]  ts;
  } rec_t;

  st_t           state;
  rec_t          rec, out_q;
  logic [7:0]    xacc;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic          rng_bad, is_start;
  logic          cfg_we_q, pc_start_q, frame_err_q, busy_q;

  logic [7:0] d;
  logic       rv, in_frame, tmo, abort, done, fire;

  assign d        = bus.rx_data;
  assign rv       = bus.rx_valid;
  assign in_frame = (state == HDR) || (state == BODY) || (state == CHK) || (state == START_CHK);

  // Timeout beats any byte arriving in the same cycle.
  always_comb begin
    tmo   = in_frame && (timer == TMO_LAST);
    abort = 1'b0;
    done  = 1'b0;
    if (tmo) abort = 1'b1;
    else if (rv) begin
      case (state)
        HDR:       abort = (d != START_CH) && (d >= NCH_B);
        CHK:       begin abort = (d != xacc) || rng_bad; done = !abort; end
        START_CHK: begin abort = (d != START_CH);        done = !abort; end
        default:   ;
      endcase
    end
    if (state == COMMIT) done = 1'b1;
    fire = done && !bus.run_active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rec         <= '0;
      out_q       <= '0;
      xacc        <= '0;
      idx         <= '0;
      timer       <= '0;
      rng_bad     <= 1'b0;
      is_start    <= 1'b0;
      cfg_we_q    <= 1'b0;
      pc_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg_we_q    <= 1'b0;
      pc_start_q  <= 1'b0;
      frame_err_q <= abort || (state == COMMIT && rv);
      if (abort || fire) begin
        state   <= IDLE;
        busy_q  <= 1'b0;
        xacc    <= '0;
        idx     <= '0;
        timer   <= '0;
        rng_bad <= 1'b0;
        if (fire) begin
          if (is_start) pc_start_q <= 1'b1;
          else begin
            cfg_we_q <= 1'b1;
            out_q    <= rec;
          end
        end
      end else if (done) begin
        state <= COMMIT;
      end else begin
        if (in_frame) timer <= rv ? '0 : timer + TW'(1);
        if (rv) begin
          case (state)
            IDLE: if (d == SYNC) begin
              state  <= HDR;
              busy_q <= 1'b1;
            end
            HDR: begin
              is_start <= (d == START_CH);
              state    <= (d == START_CH) ? START_CHK : BODY;
              if (d != START_CH) begin
                rec.ch <= d;
                xacc   <= d;
              end
            end
            BODY: begin
              idx  <= idx + 4'd1;
              xacc <= xacc ^ d;
              case (idx)
                4'd0: begin rec.drt[16] <= d[0]; rng_bad <= rng_bad | (|d[7:1]); end
                4'd1: rec.drt[15:8] <= d;
                4'd2: rec.drt[7:0]  <= d;
                4'd3: begin rec.del[16] <= d[0]; rng_bad <= rng_bad | (|d[7:1]); end
                4'd4: rec.del[15:8] <= d;
                4'd5: rec.del[7:0]  <= d;
                4'd6: begin rec.mpl <= d[4:0]; rng_bad <= rng_bad | (|d[7:5]); end
                4'd7: begin rec.mdl <= d[4:0]; rng_bad <= rng_bad | (|d[7:5]); end
                4'd8: begin rec.ts  <= d[3:0]; rng_bad <= rng_bad | (|d[7:4]); state <= CHK; end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.cfg_we    = cfg_we_q;
  assign bus.cfg_ch    = out_q.ch;
  assign bus.cfg_drt   = out_q.drt;
  assign bus.cfg_del   = out_q.del;
  assign bus.cfg_mpl   = out_q.mpl;
  assign bus.cfg_mdl   = out_q.mdl;
  assign bus.cfg_ts    = out_q.ts;
  assign bus.pc_start  = pc_start_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
